// File: rtl/csr_timer_bank_if.sv
// CSR access bus for the timer bank.
// Shared address for read and write, masked write data, combinational read data.
interface csr_timer_bank_if;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;

  modport master (
    output csr_num, csr_we, csr_wmask, csr_wvalue,
    input  csr_rvalue
  );

  modport slave (
    input  csr_num, csr_we, csr_wmask, csr_wvalue,
    output csr_rvalue
  );
endinterface

// File: rtl/csr_timer_bank.sv
// Bank of CSR-mapped down-counting timers with an interrupt status/enable pair.
// Interrupt request and index are registered from IS & LIE.
module csr_timer_bank #(
  parameter int          NUM_TIMERS = 2,
  parameter int          CNT_WIDTH  = 32,
  parameter logic [13:0] BASE_NUM   = 14'h0040
) (
  input  logic                   clk,
  input  logic                   resetn,
  csr_timer_bank_if.slave        csr,
  input  logic [7:0]             hw_int_in,
  input  logic                   crmd_ie,
  output logic                   has_int,
  output logic [3:0]             int_idx
);

  localparam int IW = 10 + NUM_TIMERS;
  localparam logic [CNT_WIDTH-1:0] ONES = '1;
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] tcfg  [NUM_TIMERS];
  logic [CNT_WIDTH-1:0] cnt   [NUM_TIMERS];
  logic [CNT_WIDTH-1:0] cfg_m [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] tp;
  logic [NUM_TIMERS-1:0] cfg_we;
  logic [NUM_TIMERS-1:0] clr_we;
  logic [7:0]  hw;
  logic [1:0]  sw;
  logic [IW-1:0] lie;
  logic [IW-1:0] is_vec;
  logic [IW-1:0] pend;
  logic [31:0] lie_m;
  logic [31:0] is_m;
  logic [31:0] rdata;
  logic [3:0]  pend_idx;
  logic        lie_we;
  logic        is_we;
  logic        clr_bit;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] m,
    input logic [31:0] v
  );
    return (m & v) | (~m & old);
  endfunction

  always_comb begin
    cfg_we = '0;
    clr_we = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      cfg_we[i] = csr.csr_we &&
        (csr.csr_num == BASE_NUM + 14'(4 * i));
      clr_we[i] = csr.csr_we &&
        (csr.csr_num == BASE_NUM + 14'(4 * i + 2));
      cfg_m[i] = CNT_WIDTH'(merge(32'(tcfg[i]),
        csr.csr_wmask, csr.csr_wvalue));
    end
  end

  assign lie_we  = csr.csr_we && (csr.csr_num == BASE_NUM + 14'd16);
  assign is_we   = csr.csr_we && (csr.csr_num == BASE_NUM + 14'd17);
  assign lie_m   = merge(32'(lie), csr.csr_wmask, csr.csr_wvalue);
  assign is_m    = merge(32'(sw), csr.csr_wmask, csr.csr_wvalue);
  assign clr_bit = csr.csr_wmask[0] & csr.csr_wvalue[0];
  assign is_vec  = {tp, hw, sw};
  assign pend    = is_vec & lie;

  // A TCFG write with en set restarts the count and wins over counting
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        tcfg[i] <= '0;
        cnt[i]  <= ONES;
      end
      tp <= '0;
    end else begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (cfg_we[i])
          tcfg[i] <= cfg_m[i];
        if (cfg_we[i] && cfg_m[i][0])
          cnt[i] <= {cfg_m[i][CNT_WIDTH-1:2], 2'b00};
        else if (tcfg[i][0] && cnt[i] != ONES) begin
          if (cnt[i] == '0 && tcfg[i][1])
            cnt[i] <= {tcfg[i][CNT_WIDTH-1:2], 2'b00};
          else
            cnt[i] <= cnt[i] - ONE;
        end
        if (tcfg[i][0] && cnt[i] == '0)
          tp[i] <= 1'b1;
        else if (clr_we[i] && clr_bit)
          tp[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hw      <= '0;
      sw      <= '0;
      lie     <= '0;
      has_int <= 1'b0;
      int_idx <= '0;
    end else begin
      hw      <= hw_int_in;
      if (is_we)
        sw <= is_m[1:0];
      if (lie_we)
        lie <= lie_m[IW-1:0];
      has_int <= crmd_ie & (|pend);
      int_idx <= pend_idx;
    end
  end

  always_comb begin
    pend_idx = '0;
    for (int i = 0; i < IW; i++)
      if (pend[i])
        pend_idx = 4'(i);
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (csr.csr_num == BASE_NUM + 14'(4 * i))
        rdata = 32'(tcfg[i]);
      if (csr.csr_num == BASE_NUM + 14'(4 * i + 1))
        rdata = 32'(cnt[i]);
    end
    if (csr.csr_num == BASE_NUM + 14'd16)
      rdata = 32'(lie);
    if (csr.csr_num == BASE_NUM + 14'd17)
      rdata = 32'(is_vec);
  end

  assign csr.csr_rvalue = rdata;

endmodule
